// File: rtl/stride_counter.sv
// Programmable-stride index counter: start, start+stride, ... up to an inclusive
// limit, then wraps back to start or stops with a done pulse.
// Ports: clk/reset (async, active-high); load + start_val/stride/limit/wrap_mode
//   capture a new sequence; enable advances one step; count/busy/wrapped/done are
//   registered, last is combinational (next step would pass the limit).
module stride_counter #(
  parameter int COUNT_LEN    = 10,
  parameter int RESET_VAL    = 1,
  parameter int RESET_STRIDE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_LEN:0] start_val,
  input  logic [COUNT_LEN:0] stride,
  input  logic [COUNT_LEN:0] limit,
  input  logic               wrap_mode,
  input  logic               enable,
  output logic [COUNT_LEN:0] count,
  output logic               busy,
  output logic               last,
  output logic               wrapped,
  output logic               done
);

  localparam int W = COUNT_LEN + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   start_q, start_d;
  logic [W-1:0]   stride_q, stride_d;
  logic [W-1:0]   limit_q, limit_d;
  logic           wrap_q, wrap_d;
  logic           busy_q, busy_d;
  logic           wrapped_q, wrapped_d;
  logic           done_q, done_d;

  // One extra bit so a step past the top of the range shows up as a carry
  // rather than silently aliasing to a small legal index.
  logic [W:0]     nxt;
  logic           over;

  assign nxt  = {1'b0, count_q} + {1'b0, stride_q};
  assign over = nxt[W] | (nxt[W-1:0] > limit_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    start_d   = start_q;
    stride_d  = stride_q;
    limit_d   = limit_q;
    wrap_d    = wrap_q;
    wrapped_d = 1'b0;
    done_d    = 1'b0;

    if (load) begin
      start_d  = start_val;
      stride_d = stride;
      limit_d  = limit;
      wrap_d   = wrap_mode;
      count_d  = start_val;
      // A start already past the limit is an empty sequence: finish at once.
      if (start_val <= limit) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end else if (enable && (state_q == ST_RUN)) begin
      if (!over) begin
        count_d = nxt[W-1:0];
      end else if (wrap_q) begin
        count_d   = start_q;
        wrapped_d = 1'b1;
      end else begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      count_q   <= W'(RESET_VAL);
      start_q   <= W'(RESET_VAL);
      stride_q  <= W'(RESET_STRIDE);
      limit_q   <= '1;
      wrap_q    <= 1'b1;
      busy_q    <= 1'b1;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      start_q   <= start_d;
      stride_q  <= stride_d;
      limit_q   <= limit_d;
      wrap_q    <= wrap_d;
      busy_q    <= busy_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
    end
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign wrapped = wrapped_q;
  assign done    = done_q;
  assign last    = (state_q == ST_RUN) && over;

endmodule

// File: tb/tb_stride_counter.sv
module tb_stride_counter;

  localparam int CL = 10;
  localparam int W  = CL + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] start_val = '0;
  logic [W-1:0] stride = '0;
  logic [W-1:0] limit = '0;
  logic         wrap_mode = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] count;
  logic         busy, last, wrapped, done;

  stride_counter #(.COUNT_LEN(CL), .RESET_VAL(1), .RESET_STRIDE(2)) dut (
    .clk(clk), .reset(reset), .load(load), .start_val(start_val),
    .stride(stride), .limit(limit), .wrap_mode(wrap_mode), .enable(enable),
    .count(count), .busy(busy), .last(last), .wrapped(wrapped), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic [W-1:0] sv;
    logic [W-1:0] st;
    logic [W-1:0] lim;
    logic         wm;
    logic         en;
    logic [W-1:0] e_count;
    logic         e_busy;
    logic         e_last;
    logic         e_wrapped;
    logic         e_done;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_bad = 0;
  int   b_def, b_top, b_stop, b_wrap, b_ldn, b_post, b_done;

  task automatic add(input logic ld, input int sv, input int st, input int lim,
                     input logic wm, input logic en, input int c,
                     input logic b, input logic l, input logic w, input logic d);
    vec_t v;
    v.ld = ld; v.sv = W'(sv); v.st = W'(st); v.lim = W'(lim); v.wm = wm; v.en = en;
    v.e_count = W'(c); v.e_busy = b; v.e_last = l; v.e_wrapped = w; v.e_done = d;
    vecs.push_back(v);
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] c, input logic b,
                           input logic l, input logic w, input logic d);
    n_applied++;
    if (count !== c) begin n_bad++; $display("FAIL %s count got %0d want %0d", tag, count, c); end
    if (busy !== b) begin n_bad++; $display("FAIL %s busy got %b want %b", tag, busy, b); end
    if (last !== l) begin n_bad++; $display("FAIL %s last got %b want %b", tag, last, l); end
    if (wrapped !== w) begin n_bad++; $display("FAIL %s wrapped got %b want %b", tag, wrapped, w); end
    if (done !== d) begin n_bad++; $display("FAIL %s done got %b want %b", tag, done, d); end
  endtask

  // Applies vecs[lo..hi-1], one clock edge each, starting from a falling edge.
  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      load = vecs[i].ld; start_val = vecs[i].sv; stride = vecs[i].st;
      limit = vecs[i].lim; wrap_mode = vecs[i].wm; enable = vecs[i].en;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy,
                vecs[i].e_last, vecs[i].e_wrapped, vecs[i].e_done);
      @(negedge clk);
    end
    load = 1'b0; enable = 1'b0;
  endtask

  initial begin
    //   ld sv  st lim  wm en  count busy last wrp done
    add(0, 0, 0, 0,    0, 1,  3,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  5,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  7,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  9,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  11,   1, 0, 0, 0);
    b_def = vecs.size();
    add(0, 0, 0, 0,    0, 1,  2047, 1, 1, 0, 0);
    add(0, 0, 0, 0,    0, 1,  1,    1, 0, 1, 0);
    add(0, 0, 0, 0,    0, 0,  1,    1, 0, 0, 0);
    b_top = vecs.size();
    add(1, 4, 3, 13,   0, 0,  4,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  7,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  10,   1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  13,   1, 1, 0, 0);
    add(0, 0, 0, 0,    0, 0,  13,   1, 1, 0, 0);
    add(0, 0, 0, 0,    0, 1,  13,   0, 0, 0, 1);
    add(0, 0, 0, 0,    0, 1,  13,   0, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  13,   0, 0, 0, 0);
    b_stop = vecs.size();
    add(1, 4, 3, 13,   1, 0,  4,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  7,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  10,   1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  13,   1, 1, 0, 0);
    add(0, 0, 0, 0,    0, 1,  4,    1, 0, 1, 0);
    add(0, 0, 0, 0,    0, 1,  7,    1, 0, 0, 0);
    b_wrap = vecs.size();
    add(1, 0, 5, 40,   1, 1,  0,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  5,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  10,   1, 0, 0, 0);
    b_ldn = vecs.size();
    add(0, 0, 0, 0,    0, 1,  3,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  5,    1, 0, 0, 0);
    b_post = vecs.size();
    add(1, 20, 1, 10,  1, 0,  20,   0, 0, 0, 1);
    add(0, 0, 0, 0,    0, 1,  20,   0, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  20,   0, 0, 0, 0);
    add(1, 6, 0, 9,    0, 1,  6,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  6,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  6,    1, 0, 0, 0);
    add(0, 0, 0, 0,    0, 1,  6,    1, 0, 0, 0);
    b_done = vecs.size();

    // Reset state, held across edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 11'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    run_range(0, b_def);

    // Walk up to 2045 (1017 more steps from 11), then the table crosses the top.
    enable = 1'b1;
    repeat (1017) @(posedge clk);
    #1;
    check_all("at2045", 11'd2045, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    run_range(b_def, b_top);

    run_range(b_top, b_stop);
    run_range(b_stop, b_wrap);
    run_range(b_wrap, b_ldn);

    // Asynchronous reset between edges while count is 10.
    #2 reset = 1'b1;
    #1;
    check_all("midreset", 11'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_range(b_ldn, b_post);

    run_range(b_post, b_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
    $finish;
  end

endmodule

// File: doc/stride_counter.md
# stride_counter

Parametrised programmable-stride index counter for the column-wise sparse-dense multiplier. It generates element/column index sequences of the form start, start+stride, start+2·stride, … up to a programmable limit, then either wraps or stops with a done pulse. Configuration is loaded at run time. After reset, with no load, it behaves exactly like the fixed odd-index counter: 1, 3, 5, … with modulo wrap.

## Interface
- `COUNT_LEN`, default 10: counter MSB index. All count, start, stride and limit buses are `COUNT_LEN+1` bits wide (W).
- `RESET_VAL`, default 1: count and captured start value after reset.
- `RESET_STRIDE`, default 2: captured stride after reset.

Ports (clock and reset first):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset; one clock domain only.
- `load`  in  1  capture configuration and restart the sequence.
- `start_val`  in  W  first index of the sequence; sampled on `load`.
- `stride`  in  W  increment per step; sampled on `load`.
- `limit`  in  W  largest legal index, inclusive; sampled on `load`.
- `wrap_mode`  in  1  1 = restart at start at the end of the sequence, 0 = stop; sampled on `load`.
- `enable`  in  1  advance one step.
- `count`  out  W  current index (registered).
- `busy`  out  1  high in the RUN state.
- `last`  out  1  combinational: in RUN, the next step would exceed `limit`.
- `wrapped`  out  1  registered 1-cycle pulse when `count` reloads to the start value.
- `done`  out  1  registered 1-cycle pulse on entry to the DONE state.

## Operation
- Internal registers:
  - `start_r`, `stride_r`, `limit_r`, `wrap_r`.
  - State: RUN or DONE.
- Reset, asynchronous and immediate:
  - Outputs: `count`=RESET_VAL, `busy`=1, `wrapped`=0, `done`=0.
  - Registers: `start_r`=RESET_VAL, `stride_r`=RESET_STRIDE, `limit_r`=all ones, `wrap_r`=1, state RUN.
- Step sum: `nxt` = `count` + `stride_r`, computed in W+1 bits. `over` = carry out OR `nxt[W-1:0]` > `limit_r`.
- Priority per clock edge: reset > `load` > `enable` > hold.
- `load`:
  - Capture all four config inputs and set `count`=`start_val`.
  - If `start_val` ≤ `limit`: go to RUN.
  - Otherwise: go to DONE and assert `done` next cycle.
  - `load` ignores `enable` in the same cycle and clears any pending `wrapped`.
- RUN with `enable`:
  - If not `over`: `count`=`nxt`.
  - If `over` and `wrap_r`=1: `count`=`start_r`, `wrapped`=1 for one cycle, stay in RUN.
  - If `over` and `wrap_r`=0: `count` holds, go to DONE, `done`=1 for one cycle.
- RUN without `enable`: everything holds. `wrapped` and `done` return to 0.
- DONE:
  - `enable` is ignored and `count` holds.
  - `busy`=0 and `last`=0.
  - Exit only through `load` or reset.
- `stride`=0: `count` never changes. `over` can never be true when `count` ≤ `limit_r`, so there is no wrap and no done.
- `last` = RUN AND `over`. It is independent of `enable`.

## Timing
- `count`, `busy`, `wrapped` and `done` change only on the rising edge of `clk`, except on reset assertion, which acts immediately.
- Latency:
  - `load` to new `count`: 1 cycle.
  - `enable` to next index: 1 cycle.
  - Terminating `enable` to `done`: 1 cycle, coincident with `busy` falling.
- `enable` may be held continuously: one index per cycle, with no bubble at a wrap.
- Reset release: the first `enable` sampled on the next edge advances from RESET_VAL.

## Test plan
- Defaults: release reset, hold `enable` 5 cycles -> `count` 1, 3, 5, 7, 9, 11. Force `count`=2045 and step twice -> 2047 then 1, with `wrapped` pulsing on that second edge.
- Load start=4, stride=3, limit=13, wrap=0, then hold `enable` -> 4, 7, 10, 13; `last`=1 while 13 is held. The next edge gives `done`=1 for 1 cycle, `busy`=0, and `count` stays 13 under further `enable`.
- Same config with wrap=1 -> 4, 7, 10, 13, 4, 7; `wrapped`=1 only in the cycle `count`=4 reappears; `done` never asserts.
- `load` (start=0, stride=5, limit=40) and `enable` in the same cycle -> `count`=0 next cycle, not 5; the following `enable` gives 5.
- Assert `reset` mid-cycle while `count`=10 in RUN -> `count`=1 and `busy`=1 immediately, before the next edge. After release with stride 2 restored: 3, 5.
- Load start=20, limit=10 -> `count`=20, state DONE, `done` pulses 1 cycle, and `enable` has no effect. Load stride=0, start=6, limit=9 -> `count` stays 6 under `enable`, with no `done` or `wrapped`.
